// File: rtl/rcc_rst_pkg.sv
//------------------------------------------------------------------------------
// Module      : rcc_rst_pkg
// Description : Shared state encoding, reset-flag layout and helpers for the
//               RCC system reset generator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rcc_rst_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_WAIT_PIN = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_RUN      = 2'd3
  } rst_state_t;

  localparam int RSTF_W    = 7;
  localparam int RSTF_PIN  = 0;
  localparam int RSTF_BOR  = 1;
  localparam int RSTF_SFT  = 2;
  localparam int RSTF_IWDG = 3;
  localparam int RSTF_WWDG = 4;
  localparam int RSTF_LPWR = 5;
  localparam int RSTF_POR  = 6;

  localparam logic [RSTF_W-1:0] RSTF_POR_VAL = 7'b100_0001;

  // Internal request vector order: {LPWR, WWDG, IWDG, SFT, BOR}
  localparam int REQ_W = 5;

  // Internal sources drive the pad, so any of them also marks PIN.
  function automatic logic [RSTF_W-1:0] req_to_flags(input logic [REQ_W-1:0] req,
                                                     input logic pin_low);
    logic [RSTF_W-1:0] f;
    f                                = '0;
    f[RSTF_LPWR:RSTF_BOR]            = req;
    f[RSTF_PIN]                      = pin_low | (|req);
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bb_sync2.sv
//------------------------------------------------------------------------------
// Module      : bb_sync2
// Description : Building-block 2-flop synchroniser with per-bit reset value.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bb_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/rcc_rst_pin_filt.sv
//------------------------------------------------------------------------------
// Module      : rcc_rst_pin_filt
// Description : NRST debounce; the level follows the input only after
//               FILT_CYCLES consecutive equal samples. Resets to 1.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rcc_rst_pin_filt #(
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_pin
);

  localparam int                  c_cnt_w    = (FILT_CYCLES > 2) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(FILT_CYCLES - 1);

  logic               r_lvl;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_diff;
  logic               w_flip;

  // The sample arriving this cycle counts as the last one of the run,
  // so the new level is forwarded without waiting for r_lvl to update.
  assign w_diff = (i_pin != r_lvl);
  assign w_flip = w_diff && (r_cnt == c_cnt_last);
  assign o_pin  = w_flip ? i_pin : r_lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl <= 1'b1;
      r_cnt <= '0;
    end else if (w_flip) begin
      r_lvl <= i_pin;
      r_cnt <= '0;
    end else if (w_diff) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rcc_rst_gen.sv
//------------------------------------------------------------------------------
// Module      : rcc_rst_gen
// Description : System reset generator: merges POR/NRST/BOR/SW/IWDG/WWDG/LPWR
//               into a stretched sys_rst_n, drives the NRST pad and keeps
//               sticky reset-cause flags. Optional NRST debounce under the
//               RCC_RST_PIN_FILTER_EN macro.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rcc_rst_gen
  import rcc_rst_pkg::*;
#(
  parameter int HOLD_CYCLES     = 20,
  parameter int PIN_FILT_CYCLES = 4
) (
  input  logic              hsi_origin_clk,
  input  logic              por_rst,
  input  logic              pin_rst_n,
  input  logic              bor_req,
  input  logic              sw_rst_req,
  input  logic              iwdg_rst_req,
  input  logic              wwdg_rst_req,
  input  logic              lpwr_rst_req,
  input  logic              rmvf,
  output logic              sys_rst_n,
  output logic              nrst_drive,
  output logic [RSTF_W-1:0] rst_flags
);

  localparam int                 c_cnt_w    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(HOLD_CYCLES - 1);

  logic [REQ_W:0]     w_sync;
  logic [REQ_W-1:0]   w_req;
  logic [REQ_W-1:0]   w_req_new;
  logic               w_pin_sync;
  logic               w_pin_lvl;
  logic [RSTF_W-1:0]  w_set;
  logic               w_hit;

  rst_state_t         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_sys_rst_n;
  logic               r_nrst_drive;
  logic [RSTF_W-1:0]  r_flags;
  logic [REQ_W-1:0]   r_req_prev;

  bb_sync2 #(
    .WIDTH   (REQ_W + 1),
    .RST_VAL (6'b10_0000)
  ) u_sync (
    .clk (hsi_origin_clk),
    .rst (por_rst),
    .i_d ({pin_rst_n, lpwr_rst_req, wwdg_rst_req, iwdg_rst_req, sw_rst_req, bor_req}),
    .o_q (w_sync)
  );

  assign w_req      = w_sync[REQ_W-1:0];
  assign w_pin_sync = w_sync[REQ_W];

`ifdef RCC_RST_PIN_FILTER_EN
  rcc_rst_pin_filt #(
    .FILT_CYCLES (PIN_FILT_CYCLES)
  ) u_pin_filt (
    .clk   (hsi_origin_clk),
    .rst   (por_rst),
    .i_pin (w_pin_sync),
    .o_pin (w_pin_lvl)
  );
`else
  assign w_pin_lvl = w_pin_sync;
`endif

  assign w_req_new = w_req & ~r_req_prev;

  // While asserting, only fresh request edges restart the hold; a pulse that
  // started the sequence must not keep extending it. The pin is ignored
  // outside ST_RUN because our own pad drive pulls it low.
  always_comb begin
    w_set = '0;
    case (r_state)
      ST_ASSERT:               w_set = req_to_flags(w_req_new, 1'b0);
      ST_WAIT_PIN, ST_RELEASE: w_set = req_to_flags(w_req, 1'b0);
      ST_RUN:                  w_set = req_to_flags(w_req, ~w_pin_lvl);
      default:                 w_set = '0;
    endcase
    w_hit = |w_set;
  end

  always_ff @(posedge hsi_origin_clk or posedge por_rst) begin
    if (por_rst) begin
      r_state      <= ST_ASSERT;
      r_cnt        <= '0;
      r_sys_rst_n  <= 1'b0;
      r_nrst_drive <= 1'b1;
      r_flags      <= RSTF_POR_VAL;
      r_req_prev   <= '0;
    end else begin
      r_flags    <= (rmvf ? '0 : r_flags) | w_set;
      r_req_prev <= w_req;

      case (r_state)
        ST_ASSERT: begin
          if (w_hit) begin
            r_cnt <= '0;
          end else if (r_cnt == c_cnt_last) begin
            r_state      <= ST_WAIT_PIN;
            r_nrst_drive <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end

        ST_WAIT_PIN: begin
          if (w_hit) begin
            r_state      <= ST_ASSERT;
            r_cnt        <= '0;
            r_nrst_drive <= 1'b1;
          end else if (w_pin_lvl) begin
            r_state <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (w_hit) begin
            r_state      <= ST_ASSERT;
            r_cnt        <= '0;
            r_nrst_drive <= 1'b1;
          end else begin
            r_state     <= ST_RUN;
            r_sys_rst_n <= 1'b1;
          end
        end

        ST_RUN: begin
          if (w_hit) begin
            r_state      <= ST_ASSERT;
            r_cnt        <= '0;
            r_sys_rst_n  <= 1'b0;
            r_nrst_drive <= 1'b1;
          end
        end

        default: begin
          r_state      <= ST_ASSERT;
          r_cnt        <= '0;
          r_sys_rst_n  <= 1'b0;
          r_nrst_drive <= 1'b1;
        end
      endcase
    end
  end

  assign sys_rst_n  = r_sys_rst_n;
  assign nrst_drive = r_nrst_drive;
  assign rst_flags  = r_flags;

endmodule

`default_nettype wire
